// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares one L2 upstream line port between two L1 requesters (port 0 = I-side,
// port 1 = D-side). One line transaction is in flight at a time. Grants are
// round-robin, and the single downstream response goes back to the port that
// owns the transaction. A response watchdog recovers from a hung downstream.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   mX_req_valid_i/_ready_o        requester handshake (X = 0, 1)
//   mX_req_rw_i                    0 = readline, 1 = writeline
//   mX_req_addr_i, mX_req_wline_i  line address, write line data
//   mX_resp_valid_o                one-cycle response pulse to the owner
//   mX_resp_rline_o                last registered response line (shared)
//   dn_req_*                       forwarded request towards L2
//   dn_resp_valid_i/_rline_i       downstream response pulse and read data
//   err_timeout_o                  sticky watchdog flag, cleared only by reset
module l2_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_valid_i,
    output logic              m0_req_ready_o,
    input  logic              m0_req_rw_i,
    input  logic [ADDR_W-1:0] m0_req_addr_i,
    input  logic [LINE_W-1:0] m0_req_wline_i,
    output logic              m0_resp_valid_o,
    output logic [LINE_W-1:0] m0_resp_rline_o,

    input  logic              m1_req_valid_i,
    output logic              m1_req_ready_o,
    input  logic              m1_req_rw_i,
    input  logic [ADDR_W-1:0] m1_req_addr_i,
    input  logic [LINE_W-1:0] m1_req_wline_i,
    output logic              m1_resp_valid_o,
    output logic [LINE_W-1:0] m1_resp_rline_o,

    output logic              dn_req_valid_o,
    input  logic              dn_req_ready_i,
    output logic              dn_req_rw_o,
    output logic [ADDR_W-1:0] dn_req_addr_o,
    output logic [LINE_W-1:0] dn_req_wline_o,
    input  logic              dn_resp_valid_i,
    input  logic [LINE_W-1:0] dn_resp_rline_i,

    output logic              err_timeout_o
);

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          WDOG_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                last_q,  last_d;
    logic                owner_q, owner_d;
    logic                rw_q,    rw_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rline_q, rline_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                err_q,   err_d;

    logic                grant0;
    logic                grant1;

    // Round-robin: on a tie the port that did not win last time is granted.
    assign grant0 = m0_req_valid_i & (~m1_req_valid_i | last_q);
    assign grant1 = m1_req_valid_i & (~m0_req_valid_i | ~last_q);

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant0 | grant1) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    rw_d    = grant1 ? m1_req_rw_i    : m0_req_rw_i;
                    addr_d  = grant1 ? m1_req_addr_i  : m0_req_addr_i;
                    wline_d = grant1 ? m1_req_wline_i : m0_req_wline_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dn_req_ready_i) begin
                    cnt_d = '0;
                    // A response arriving with the acceptance is taken at once.
                    if (dn_resp_valid_i) begin
                        rline_d = dn_resp_rline_i;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dn_resp_valid_i) begin
                    rline_d = dn_resp_rline_i;
                    state_d = S_RESP;
                end else if (WDOG_EN && (cnt_q == CNT_W'(TMO_LAST))) begin
                    rline_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; ready also gated by reset.
    always_comb begin
        m0_req_ready_o  = 1'b0;
        m1_req_ready_o  = 1'b0;
        m0_resp_valid_o = 1'b0;
        m1_resp_valid_o = 1'b0;
        dn_req_valid_o  = 1'b0;

        if ((state_q == S_IDLE) && !rst_i) begin
            m0_req_ready_o = grant0;
            m1_req_ready_o = grant1;
        end
        if (state_q == S_ISSUE) begin
            dn_req_valid_o = 1'b1;
        end
        if (state_q == S_RESP) begin
            m0_resp_valid_o = ~owner_q;
            m1_resp_valid_o = owner_q;
        end
    end

    assign dn_req_rw_o     = rw_q;
    assign dn_req_addr_o   = addr_q;
    assign dn_req_wline_o  = wline_q;
    assign m0_resp_rline_o = rline_q;
    assign m1_resp_rline_o = rline_q;
    assign err_timeout_o   = err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (round-robin pointer, line memory).
module tb_l2_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned LW  = 256;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_valid, m0_req_ready, m0_req_rw, m0_resp_valid;
    logic [AW-1:0] m0_req_addr;
    logic [LW-1:0] m0_req_wline, m0_resp_rline;
    logic          m1_req_valid, m1_req_ready, m1_req_rw, m1_resp_valid;
    logic [AW-1:0] m1_req_addr;
    logic [LW-1:0] m1_req_wline, m1_resp_rline;
    logic          dn_req_valid, dn_req_ready, dn_req_rw, dn_resp_valid;
    logic [AW-1:0] dn_req_addr;
    logic [LW-1:0] dn_req_wline, dn_resp_rline;
    logic          err_timeout;

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TMO)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .m0_req_valid_i  (m0_req_valid),
        .m0_req_ready_o  (m0_req_ready),
        .m0_req_rw_i     (m0_req_rw),
        .m0_req_addr_i   (m0_req_addr),
        .m0_req_wline_i  (m0_req_wline),
        .m0_resp_valid_o (m0_resp_valid),
        .m0_resp_rline_o (m0_resp_rline),
        .m1_req_valid_i  (m1_req_valid),
        .m1_req_ready_o  (m1_req_ready),
        .m1_req_rw_i     (m1_req_rw),
        .m1_req_addr_i   (m1_req_addr),
        .m1_req_wline_i  (m1_req_wline),
        .m1_resp_valid_o (m1_resp_valid),
        .m1_resp_rline_o (m1_resp_rline),
        .dn_req_valid_o  (dn_req_valid),
        .dn_req_ready_i  (dn_req_ready),
        .dn_req_rw_o     (dn_req_rw),
        .dn_req_addr_o   (dn_req_addr),
        .dn_req_wline_o  (dn_req_wline),
        .dn_resp_valid_i (dn_resp_valid),
        .dn_resp_rline_i (dn_resp_rline),
        .err_timeout_o   (err_timeout)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: round-robin pointer and downstream line memory.
    logic          exp_last;
    logic [LW-1:0] exp_rline;
    logic [LW-1:0] mem [logic [AW-1:0]];

    function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_valid  = 1'b0;
        m1_req_valid  = 1'b0;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        m0_req_valid = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready",    LW'({m1_req_ready, m0_req_ready}), '0);
        chk("rst_dn_valid", LW'(dn_req_valid), '0);
        chk("rst_dn_rwadr", LW'({dn_req_rw, dn_req_addr}), '0);
        chk("rst_dn_wline", dn_req_wline, '0);
        chk("rst_resp_vld", LW'({m1_resp_valid, m0_resp_valid}), '0);
        chk("rst_rline0",   m0_resp_rline, '0);
        chk("rst_rline1",   m1_resp_rline, '0);
        chk("rst_err",      LW'(err_timeout), '0);
        m0_req_valid = 1'b0;
        rst = 1'b0;
        exp_last  = 1'b1;
        exp_rline = '0;
    endtask

    // One complete transaction; rdly = cycles with dn ready low, sdly = cycles
    // from downstream acceptance to response, spur = junk responses before acceptance.
    task automatic do_txn(input logic v0, input logic v1, input logic rw0, input logic rw1,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [LW-1:0] w0, input logic [LW-1:0] w1,
                          input int rdly, input int sdly, input bit spur);
        logic          g;
        logic          rw;
        logic [AW-1:0] a;
        logic [LW-1:0] w;
        logic [LW-1:0] rl;
        logic [1:0]    onehot;
        g  = (v0 && v1) ? ~exp_last : v1;
        rw = g ? rw1 : rw0;
        a  = g ? a1 : a0;
        w  = g ? w1 : w0;
        onehot = g ? 2'b10 : 2'b01;
        m0_req_valid = v0; m0_req_rw = rw0; m0_req_addr = a0; m0_req_wline = w0;
        m1_req_valid = v1; m1_req_rw = rw1; m1_req_addr = a1; m1_req_wline = w1;
        dn_req_ready = 1'b0; dn_resp_valid = 1'b0;
        #1;
        chk("grant", LW'({m1_req_ready, m0_req_ready}), LW'(onehot));
        exp_last = g;
        if (rw) begin
            rl = ~w;
            mem[a] = w;
        end else begin
            rl = mem_rd(a);
        end
        tick();
        for (int i = 0; i < rdly; i++) begin
            dn_resp_valid = spur;
            dn_resp_rline = rand_line();
            #1;
            chk("issue_ready",   LW'({m1_req_ready, m0_req_ready}), '0);
            chk("issue_valid",   LW'(dn_req_valid), LW'(1'b1));
            chk("issue_rwaddr",  LW'({dn_req_rw, dn_req_addr}), LW'({rw, a}));
            chk("issue_wline",   dn_req_wline, w);
            tick();
        end
        dn_req_ready  = 1'b1;
        dn_resp_valid = (sdly == 0);
        dn_resp_rline = (sdly == 0) ? rl : rand_line();
        #1;
        chk("accept_valid",  LW'(dn_req_valid), LW'(1'b1));
        chk("accept_rwaddr", LW'({dn_req_rw, dn_req_addr}), LW'({rw, a}));
        chk("accept_wline",  dn_req_wline, w);
        tick();
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        for (int i = 1; i < sdly; i++) begin
            #1;
            chk("wait_resp", LW'({m1_resp_valid, m0_resp_valid, dn_req_valid}), '0);
            chk("wait_ready", LW'({m1_req_ready, m0_req_ready}), '0);
            tick();
        end
        if (sdly > 0) begin
            dn_resp_valid = 1'b1;
            dn_resp_rline = rl;
            #1;
            chk("wait_resp", LW'({m1_resp_valid, m0_resp_valid}), '0);
            tick();
        end
        dn_resp_valid = 1'b0;
        dn_resp_rline = rand_line();
        #1;
        chk("resp_owner",  LW'({m1_resp_valid, m0_resp_valid}), LW'(onehot));
        chk("resp_ready",  LW'({m1_req_ready, m0_req_ready}), '0);
        chk("resp_rline0", m0_resp_rline, rl);
        chk("resp_rline1", m1_resp_rline, rl);
        exp_rline = rl;
        tick();
        chk("resp_single", LW'({m1_resp_valid, m0_resp_valid}), '0);
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
    endtask

    // Downstream accepts but never answers; expect recovery after TMO cycles.
    task automatic do_timeout(input logic p, input logic [AW-1:0] a);
        m0_req_valid = ~p; m0_req_rw = 1'b0; m0_req_addr = a;
        m1_req_valid = p;  m1_req_rw = 1'b0; m1_req_addr = a;
        dn_req_ready = 1'b0; dn_resp_valid = 1'b0;
        #1;
        chk("tmo_grant", LW'({m1_req_ready, m0_req_ready}), LW'(p ? 2'b10 : 2'b01));
        exp_last = p;
        tick();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        dn_req_ready = 1'b1;
        tick();
        dn_req_ready = 1'b0;
        for (int k = 1; k <= int'(TMO); k++) begin
            chk("tmo_wait_resp", LW'({m1_resp_valid, m0_resp_valid}), '0);
            chk("tmo_wait_err",  LW'(err_timeout), '0);
            tick();
        end
        chk("tmo_resp",  LW'({m1_resp_valid, m0_resp_valid}), LW'(p ? 2'b10 : 2'b01));
        chk("tmo_rline", m0_resp_rline, '0);
        chk("tmo_err",   LW'(err_timeout), LW'(1'b1));
        exp_rline = '0;
        tick();
        chk("tmo_single", LW'({m1_resp_valid, m0_resp_valid}), '0);
        chk("tmo_sticky", LW'(err_timeout), LW'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0]    v;
        logic [AW-1:0] ra0, ra1;
        rst = 1'b1;
        idle_inputs();
        m0_req_rw = 1'b0; m0_req_addr = '0; m0_req_wline = '0;
        m1_req_rw = 1'b0; m1_req_addr = '0; m1_req_wline = '0;
        dn_resp_rline = '0;

        do_reset();

        // Continuous contention after reset: port 0 first, then strict alternation.
        for (int i = 0; i < 4; i++)
            do_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, '0, '0, 0, 1, 1'b0);

        // Single read from port 0 returning the A5 pattern two cycles after acceptance.
        mem[32'h40] = {32{8'hA5}};
        do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, '0, '0, '0, 0, 2, 1'b0);

        // Writeline from port 1 stalled five cycles by the downstream.
        do_txn(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h300, '0, rand_line(), 5, 1, 1'b0);

        // Spurious downstream responses while idle are ignored.
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            dn_resp_valid = 1'b1;
            dn_resp_rline = rand_line();
            tick();
            chk("spur_resp",  LW'({m1_resp_valid, m0_resp_valid, dn_req_valid}), '0);
            chk("spur_rline", m0_resp_rline, exp_rline);
        end
        dn_resp_valid = 1'b0;
        do_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h140, 32'h240, '0, '0, 1, 3, 1'b1);

        // Watchdog, then a normal transaction with the flag still set.
        do_timeout(1'b0, 32'h500);
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h540, '0, '0, 0, 2, 1'b0);
        chk("err_sticky", LW'(err_timeout), LW'(1'b1));

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            ra0 = AW'($urandom_range(0, 7)) << 6;
            ra1 = AW'($urandom_range(0, 7)) << 6;
            do_txn(v[0], v[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ra0, ra1, rand_line(), rand_line(),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 1)));
        end

        // Reset during WAIT aborts silently; port 0 wins the next tie.
        do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h600, '0, '0, '0, 0, 0, 1'b0);
        m0_req_valid = 1'b1; m0_req_addr = 32'h640; m0_req_rw = 1'b0;
        #1;
        chk("pre_rst_grant", LW'({m1_req_ready, m0_req_ready}), LW'(2'b01));
        tick();
        m0_req_valid = 1'b0;
        dn_req_ready = 1'b1;
        tick();
        dn_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dn_resp_valid = 1'b1;
        dn_resp_rline = rand_line();
        #1;
        chk("abort_dn_valid", LW'(dn_req_valid), '0);
        chk("abort_dn_addr",  LW'(dn_req_addr), '0);
        chk("abort_resp",     LW'({m1_resp_valid, m0_resp_valid}), '0);
        chk("abort_rline",    m0_resp_rline, '0);
        chk("abort_err",      LW'(err_timeout), '0);
        tick();
        chk("late_resp",      LW'({m1_resp_valid, m0_resp_valid, dn_req_valid}), '0);
        dn_resp_valid = 1'b0;
        exp_last  = 1'b1;
        exp_rline = '0;
        do_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h740, '0, '0, 0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
